// File: rtl/planning_move_scheduler.sv
// Round-robin move scheduler for the planning plant: one agent per cycle, FIRST/INIT/RUN/HALT phases.
// Optional SCHED_GAP_EN macro inserts a mandatory idle cycle after every grant.
module planning_move_scheduler #(
    parameter int unsigned INIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_robot,
    input  logic [1:0] dir_robot,
    input  logic       req_obs1,
    input  logic [1:0] dir_obs1,
    input  logic       req_obs2,
    input  logic [1:0] dir_obs2,
    input  logic       end_init,
    input  logic       error,
    output logic       move_robot,
    output logic       controllable_up,
    output logic       controllable_down,
    output logic       controllable_left,
    output logic       controllable_right,
    output logic       move_obs1_up,
    output logic       move_obs1_down,
    output logic       move_obs1_left,
    output logic       move_obs1_right,
    output logic       move_obs2_up,
    output logic       move_obs2_down,
    output logic       move_obs2_left,
    output logic       move_obs2_right,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        FIRST = 2'b00,
        INIT  = 2'b01,
        RUN   = 2'b10,
        HALT  = 2'b11
    } phase_e;

    phase_e     phase_q, phase_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] rr_q, rr_d;
    logic [2:0] gnt_q, gnt_d;
    logic [3:0] dr_q, dr_d;
    logic [3:0] d1_q, d1_d;
    logic [3:0] d2_q, d2_d;
    logic       gap;
    logic       open;
    logic [2:0] elig;

    always_comb begin
`ifdef SCHED_GAP_EN
        gap = |gnt_q;
`else
        gap = 1'b0;
`endif
        open = (phase_q == INIT || phase_q == RUN) && !error && !gap;
        // robot is masked until the run phase
        elig = {req_obs2, req_obs1, req_robot && (phase_q == RUN)} & {3{open}};

        case (rr_q)
            2'd1:    gnt_d = elig[1] ? 3'b010 : elig[2] ? 3'b100 :
                             elig[0] ? 3'b001 : 3'b000;
            2'd2:    gnt_d = elig[2] ? 3'b100 : elig[0] ? 3'b001 :
                             elig[1] ? 3'b010 : 3'b000;
            default: gnt_d = elig[0] ? 3'b001 : elig[1] ? 3'b010 :
                             elig[2] ? 3'b100 : 3'b000;
        endcase

        rr_d = rr_q;
        if (gnt_d[0]) rr_d = 2'd1;
        if (gnt_d[1]) rr_d = 2'd2;
        if (gnt_d[2]) rr_d = 2'd0;

        dr_d = gnt_d[0] ? (4'b0001 << dir_robot) : 4'b0000;
        d1_d = gnt_d[1] ? (4'b0001 << dir_obs1) : 4'b0000;
        d2_d = gnt_d[2] ? (4'b0001 << dir_obs2) : 4'b0000;

        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (phase_q == INIT) cnt_d = cnt_q - 8'd1;
        if (error) begin
            phase_d = HALT;
        end else begin
            case (phase_q)
                FIRST: phase_d = INIT;
                INIT:  if (cnt_q == 8'd1 || end_init) phase_d = RUN;
                default: phase_d = phase_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= FIRST;
            cnt_q   <= 8'(INIT_CYCLES);
            rr_q    <= 2'd0;
            gnt_q   <= 3'b000;
            dr_q    <= 4'b0000;
            d1_q    <= 4'b0000;
            d2_q    <= 4'b0000;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            dr_q    <= dr_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
        end
    end

    assign move_robot = gnt_q[0];
    assign {controllable_right, controllable_left,
            controllable_down, controllable_up} = dr_q;
    assign {move_obs1_right, move_obs1_left,
            move_obs1_down, move_obs1_up} = d1_q;
    assign {move_obs2_right, move_obs2_left,
            move_obs2_down, move_obs2_up} = d2_q;
    assign phase = phase_q;

endmodule
